// File: rtl/dsp_mac_pkg.sv
// Shared definitions for the MAC array: per-channel mode encodings and default operand widths.
package dsp_mac_pkg;

  localparam int N_CH_DEF = 5;
  localparam int AW_DEF   = 30;
  localparam int DW_DEF   = 25;
  localparam int BW_DEF   = 18;
  localparam int PW_DEF   = 48;

  typedef enum logic [1:0] {
    MODE_MADD     = 2'd0,
    MODE_MAC      = 2'd1,
    MODE_MADD_D0  = 2'd2,
    MODE_MADD_D0B = 2'd3
  } mac_mode_e;

  // Only the two low encodings feed D into the pre-adder.
  function automatic logic mode_uses_d(input mac_mode_e m);
    return (m == MODE_MADD) || (m == MODE_MAC);
  endfunction

endpackage

// File: rtl/dsp_mac_lane.sv
// One MAC channel: S1 pre-add, S2 multiply, S3 post-add/accumulate with sticky overflow.
module dsp_mac_lane
  import dsp_mac_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int BW = BW_DEF,
  parameter int PW = PW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [DW-1:0] a_lo,
  input  logic signed [BW-1:0] b,
  input  logic signed [PW-1:0] c,
  input  logic signed [DW-1:0] d,
  input  logic [1:0]           mode,
  input  logic                 s2_valid,
  input  logic                 s2_clr,
  output logic [PW-1:0]        p,
  output logic                 ovf
);

  localparam int MW = DW + BW;

  mac_mode_e           mode_in;
  logic signed [DW-1:0] pre_next;
  logic signed [DW-1:0] pre_s1;
  logic signed [BW-1:0] b_s1;
  logic signed [PW-1:0] c_s1;
  mac_mode_e            mode_s1;
  logic signed [MW-1:0] prod_next;
  logic signed [MW-1:0] prod_s2;
  logic signed [PW-1:0] c_s2;
  mac_mode_e            mode_s2;
  logic signed [PW-1:0] prod_ext;
  logic signed [PW-1:0] mac_sum;
  logic                 mac_ovf;
  logic signed [PW-1:0] p_reg;
  logic signed [PW-1:0] p_next;
  logic                 ovf_reg;
  logic                 ovf_next;

  assign mode_in   = mac_mode_e'(mode);
  assign pre_next  = a_lo + (mode_uses_d(mode_in) ? d : '0);
  assign prod_next = MW'(pre_s1) * MW'(b_s1);

  always_comb begin
    prod_ext = PW'(prod_s2);
    mac_sum  = p_reg + prod_ext;
    // Signed overflow: addends agree in sign but the sum does not.
    mac_ovf  = (p_reg[PW-1] == prod_ext[PW-1]) && (mac_sum[PW-1] != p_reg[PW-1]);
    p_next   = p_reg;
    ovf_next = ovf_reg;
    if (s2_valid) begin
      if (mode_s2 == MODE_MAC) begin
        if (s2_clr) begin
          p_next   = prod_ext;
          ovf_next = 1'b0;
        end else begin
          p_next   = mac_sum;
          ovf_next = ovf_reg | mac_ovf;
        end
      end else begin
        p_next = prod_ext + c_s2;
        if (s2_clr) ovf_next = 1'b0;
      end
    end else if (s2_clr) begin
      p_next   = '0;
      ovf_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_s1  <= '0;
      b_s1    <= '0;
      c_s1    <= '0;
      mode_s1 <= MODE_MADD;
      prod_s2 <= '0;
      c_s2    <= '0;
      mode_s2 <= MODE_MADD;
      p_reg   <= '0;
      ovf_reg <= 1'b0;
    end else begin
      pre_s1  <= pre_next;
      b_s1    <= b;
      c_s1    <= c;
      mode_s1 <= mode_in;
      prod_s2 <= prod_next;
      c_s2    <= c_s1;
      mode_s2 <= mode_s1;
      p_reg   <= p_next;
      ovf_reg <= ovf_next;
    end
  end

  assign p   = p_reg;
  assign ovf = ovf_reg;

endmodule

// File: rtl/dsp_mac_array.sv
// N_CH independent MAC lanes on broadcast operands; valid/clear pipeline shared by all lanes.
module dsp_mac_array
  import dsp_mac_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF,
  parameter int BW   = BW_DEF,
  parameter int PW   = PW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  input  logic signed [PW-1:0] c,
  input  logic signed [DW-1:0] d,
  input  logic [2*N_CH-1:0]    mode,
  input  logic                 acc_clr,
  output logic                 out_valid,
  output logic [N_CH*PW-1:0]   p,
  output logic [N_CH-1:0]      ovf,
  output logic                 dout
);

  logic valid_s1_reg, valid_s2_reg, valid_s3_reg;
  logic clr_s1_reg, clr_s2_reg;
  logic signed [DW-1:0] a_lo;

  assign a_lo = a[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_s1_reg <= 1'b0;
      valid_s2_reg <= 1'b0;
      valid_s3_reg <= 1'b0;
      clr_s1_reg   <= 1'b0;
      clr_s2_reg   <= 1'b0;
    end else begin
      valid_s1_reg <= in_valid;
      valid_s2_reg <= valid_s1_reg;
      valid_s3_reg <= valid_s2_reg;
      clr_s1_reg   <= acc_clr;
      clr_s2_reg   <= clr_s1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lane
      dsp_mac_lane #(
        .DW(DW),
        .BW(BW),
        .PW(PW)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_lo    (a_lo),
        .b       (b),
        .c       (c),
        .d       (d),
        .mode    (mode[2*gi +: 2]),
        .s2_valid(valid_s2_reg),
        .s2_clr  (clr_s2_reg),
        .p       (p[gi*PW +: PW]),
        .ovf     (ovf[gi])
      );
    end
  endgenerate

  assign out_valid = valid_s3_reg;
  assign dout      = |p;

endmodule
